// File: rtl/serial_adder_unit_if.sv
// Operand/result bundle for the bit-serial adder: the requester drives start and
// operands, the unit returns ready/done and the registered result with its flags.
interface serial_adder_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  ready, done, sum, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/serial_adder_unit.sv
// Bit-serial add/subtract unit: one fullAdder slice fed one bit pair per cycle from
// operand shift registers, with a carry flop and an IDLE/RUN/DONE controller.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ ci;
    assign c = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_unit_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cmsb;
    logic             co_q;
    logic             ov_q;
    logic             zero_q;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             ready_c;
    logic             done_c;

    fullAdder u_fa (
        .a  (areg[0]),
        .b  (breg[0]),
        .ci (carry),
        .s  (fa_s),
        .c  (fa_c)
    );

    // The carry entering the MSB slice is what the signed-overflow test compares
    // against the final carry; it is only meaningful while last_bit is high.
    assign cmsb     = carry;
    assign res_next = {fa_s, res[WIDTH-1:1]};
    assign last_bit = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) next_state = RUN;
            end
            RUN: begin
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the inverted operand and a carry-in of one are
    // set up at accept time and the serial loop itself never knows the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            areg   <= '0;
            breg   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            co_q   <= 1'b0;
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                areg  <= bus.a;
                breg  <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub;
                cnt   <= '0;
                res   <= '0;
            end
        end else if (state == RUN) begin
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            res   <= res_next;
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                sum_q  <= res_next;
                co_q   <= fa_c;
                ov_q   <= cmsb ^ fa_c;
                zero_q <= (res_next == '0);
            end
        end
    end

    assign bus.ready     = ready_c;
    assign bus.done      = done_c;
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit: expected results are queued at issue time
// from an arithmetic model and popped by a monitor on every done pulse.
module tb_serial_adder_unit;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    logic   clk;
    logic   rst;
    int     checks;
    int     errors;
    int     cyc;
    exp_t   exp_q[$];
    logic [W-1:0] last_sum;

    serial_adder_unit_if #(.WIDTH(W)) bus ();

    serial_adder_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, unsigned for the carry/borrow and
    // signed for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int   ux, uy, sx, sy, r, sr;
        exp_t e;
        ux    = int'(x);
        uy    = int'(y);
        sx    = int'($signed(x));
        sy    = int'($signed(y));
        r     = s ? ux - uy : ux + uy;
        e.sum = W'(r & ((1 << W) - 1));
        e.co  = s ? (ux >= uy) : (r >= (1 << W));
        sr    = s ? sx - sy : sx + sy;
        e.ov  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.z   = (e.sum == '0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sum",       bus.sum,       e.sum);
                checkOutput("carry_out", bus.carry_out, e.co);
                checkOutput("overflow",  bus.overflow,  e.ov);
                checkOutput("zero",      bus.zero,      e.z);
            end
        end
    end

    // One operation from the start handshake to the return to IDLE. glitch pulses
    // junk requests in RUN cycle 3 and in DONE; rst_at>0 aborts in that RUN cycle.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 input bit glitch, input int rst_at);
        int   k;
        int   n;
        bit   got_done;
        exp_t e;
        e = model(x, y, s);
        @(negedge clk);
        n = 0;
        while (bus.ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_start", bus.ready, 1'b1);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.sub   = s;
        if (rst_at == 0) exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        k         = 1;
        got_done  = 1'b0;
        while (k <= 40) begin
            if (bus.done === 1'b1) begin
                checkOutput("latency", k, W + 1);
                got_done = 1'b1;
                if (glitch) begin
                    bus.start = 1'b1;
                    bus.a     = 8'hAA;
                    bus.b     = 8'h55;
                end
                break;
            end
            checkOutput("ready_low", bus.ready, 1'b0);
            if (k == 4) checkOutput("hold_sum", bus.sum, last_sum);
            if (glitch && k == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end else if (glitch) begin
                bus.start = 1'b0;
            end
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("rst_sum",       bus.sum,       '0);
                checkOutput("rst_carry_out", bus.carry_out, 1'b0);
                checkOutput("rst_overflow",  bus.overflow,  1'b0);
                checkOutput("rst_zero",      bus.zero,      1'b0);
                checkOutput("rst_done",      bus.done,      1'b0);
                checkOutput("rst_ready",     bus.ready,     1'b1);
                last_sum = '0;
                repeat (12) @(negedge clk);
                return;
            end
            @(negedge clk);
            k++;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done in 40 cycles, expected done at cycle %0d", W + 1);
            return;
        end
        last_sum = e.sum;
        if (glitch) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        @(negedge clk);
        checkOutput("done_one_cycle", bus.done,  1'b0);
        checkOutput("ready_after",    bus.ready, 1'b1);
        checkOutput("hold_after",     bus.sum,   last_sum);
        if (glitch) repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] b2b_a [3];
        logic [W-1:0] b2b_b [3];
        logic [W-1:0] b2b_s [3];
        int  idx;
        int  n_done;
        int  last_done_cyc;
        logic prev_ready;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        last_sum  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready",     bus.ready,     1'b1);
        checkOutput("reset_done",      bus.done,      1'b0);
        checkOutput("reset_sum",       bus.sum,       '0);
        checkOutput("reset_carry_out", bus.carry_out, 1'b0);
        checkOutput("reset_overflow",  bus.overflow,  1'b0);
        checkOutput("reset_zero",      bus.zero,      1'b0);
        rst = 1'b0;

        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        applyStimulus(8'h05, 8'h07, 1'b1, 1'b0, 0);
        applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, 0);
        applyStimulus(8'h33, 8'h33, 1'b1, 1'b0, 0);
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b1, 0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 4);
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom());
            rb = W'($urandom());
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs, 1'b0, 0);
        end

        // Back-to-back with start held high; next operands are loaded right after
        // each acceptance so they are in place for the following IDLE cycle.
        b2b_a = '{8'h01, 8'h02, 8'hFE};
        b2b_b = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) b2b_s[i] = model(b2b_a[i], b2b_b[i], 1'b0).sum;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = b2b_a[0];
        bus.b     = b2b_b[0];
        exp_q.push_back(model(b2b_a[0], b2b_b[0], 1'b0));
        idx           = 1;
        n_done        = 0;
        last_done_cyc = 0;
        prev_ready    = bus.ready;
        for (int t = 0; t < 60 && n_done < 3; t++) begin
            @(negedge clk);
            if (prev_ready === 1'b1 && bus.ready === 1'b0 && idx < 3) begin
                bus.a = b2b_a[idx];
                bus.b = b2b_b[idx];
                exp_q.push_back(model(b2b_a[idx], b2b_b[idx], 1'b0));
                idx++;
            end
            if (bus.done === 1'b1) begin
                if (n_done > 0) checkOutput("b2b_spacing", cyc - last_done_cyc, W + 2);
                last_done_cyc = cyc;
                n_done++;
                if (n_done == 3) bus.start = 1'b0;
            end else if (n_done > 0 && bus.ready === 1'b0) begin
                checkOutput("b2b_hold", bus.sum, b2b_s[n_done-1]);
            end
            prev_ready = bus.ready;
        end
        checkOutput("b2b_done_count", n_done, 3);
        repeat (4) @(negedge clk);
        checkOutput("b2b_final_carry", bus.carry_out, 1'b1);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
